ptrng_arbiter: RTL

- Round-robin controller sharing one ptrng_top instance among NUM_REQ requesters.
- Per grant: issues one update pulse, waits for a fresh valid, captures the 128-bit word and returns it to the granted requester over a valid/ready handshake.
- Guarantees no word is delivered twice and no stale valid is consumed.
- Watchdog timeout with automatic retry; saturating error counter for status readout.

---
 rtl/ptrng_arbiter_if.sv | 25 ++
 rtl/ptrng_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ptrng_arbiter_if.sv
// Requester handshake and PTRNG control/data signals of ptrng_arbiter.
// master = arbiter side, slave = requesters plus PTRNG side.
interface ptrng_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [127:0]       rsp_data;
    logic               ptrng_enable;
    logic               ptrng_update;
    logic               ptrng_valid;
    logic [127:0]       ptrng_data;

    modport master (
        input  req, rsp_ready, ptrng_valid, ptrng_data,
        output gnt, rsp_valid, rsp_data, ptrng_enable, ptrng_update
    );

    modport slave (
        output req, rsp_ready, ptrng_valid, ptrng_data,
        input  gnt, rsp_valid, rsp_data, ptrng_enable, ptrng_update
    );
endinterface

// File: rtl/ptrng_arbiter.sv
// Round-robin arbiter sharing one PTRNG among NUM_REQ requesters, with
// stale-valid discard, watchdog retry and a saturating timeout counter.
//
// state  | meaning
// S_IDLE | pick next requester round-robin starting at rr_ptr
// S_UPD  | one-cycle update pulse to PTRNG, arm watchdog
// S_DROP | wait for PTRNG valid to fall (discard stale word)
// S_WAIT | wait for fresh valid, capture data
// S_RESP | present word to granted requester until accepted
module ptrng_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    ptrng_arbiter_if.master arb,
    output logic            timeout_err,
    output logic [7:0]      err_cnt
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_UPD, S_DROP, S_WAIT, S_RESP} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, cur_id, sel_off, sel_id;
    logic [ID_W:0]       sel_sum;
    logic [NUM_REQ-1:0]  req_rot;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [127:0]        rsp_data_q;
    logic                latch_id, cnt_load, cnt_dec, tmo_hit, capture, accept;

    // Rotate so bit 0 is rr_ptr; lowest set bit is then the round-robin winner.
    assign req_rot = NUM_REQ'({arb.req, arb.req} >> rr_ptr);

    always_comb begin
        sel_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) sel_off = ID_W'(i);
        end
    end

    assign sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
    assign sel_id  = (sel_sum >= NREQ_W) ? ID_W'(sel_sum - NREQ_W) : sel_sum[ID_W-1:0];

    always_comb begin
        state_nxt = state;
        latch_id  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        tmo_hit   = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (|arb.req) begin
                        latch_id  = 1'b1;
                        state_nxt = S_UPD;
                    end
                end
                S_UPD: begin
                    cnt_load  = 1'b1;
                    state_nxt = S_DROP;
                end
                // Exit condition is tested first so it wins over an expiring watchdog.
                S_DROP: begin
                    cnt_dec = 1'b1;
                    if (!arb.ptrng_valid) begin
                        state_nxt = S_WAIT;
                    end else if (tmo_cnt == '0) begin
                        tmo_hit   = 1'b1;
                        state_nxt = S_UPD;
                    end
                end
                S_WAIT: begin
                    cnt_dec = 1'b1;
                    if (arb.ptrng_valid) begin
                        capture   = 1'b1;
                        state_nxt = S_RESP;
                    end else if (tmo_cnt == '0) begin
                        tmo_hit   = 1'b1;
                        state_nxt = S_UPD;
                    end
                end
                S_RESP: begin
                    if (arb.rsp_ready) begin
                        accept    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            tmo_cnt     <= '0;
            rsp_data_q  <= '0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= tmo_hit;
            if (latch_id) cur_id <= sel_id;
            if (accept) rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
            if (cnt_load) begin
                tmo_cnt <= TMO_W'(TIMEOUT - 1);
            end else if (cnt_dec && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (capture) rsp_data_q <= arb.ptrng_data;
            if (tmo_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign arb.ptrng_enable = enable;
    assign arb.ptrng_update = enable && (state == S_UPD);
    assign arb.rsp_valid    = (state == S_RESP);
    assign arb.gnt          = (state == S_RESP) ? (NUM_REQ'(1) << cur_id) : '0;
    assign arb.rsp_data     = rsp_data_q;
endmodule
